// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sequencer.
//   TTS_N   : default number of function inputs
//   DEPTH   : table depth for the default N
//   State encoding for the sequencer FSM. ST_SAMPLE is only reached when
//   TTS_SETTLE_EN is defined.
package tts_pkg;

    localparam int unsigned TTS_N = 4;
    localparam int unsigned DEPTH = 2 ** TTS_N;

    typedef logic [1:0] tts_state_t;

    localparam tts_state_t ST_IDLE   = 2'd0;
    localparam tts_state_t ST_DRIVE  = 2'd1;
    localparam tts_state_t ST_SAMPLE = 2'd2;
    localparam tts_state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/tts_vec_counter.sv
// Vector index generator for the truth-table sequencer.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : force idx to 0 (start of a sweep)
//   advance    : step idx by one
//   idx        : current vector index
//   last       : idx is the final vector (2**N-1)
module tts_vec_counter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         advance,
    output logic [N-1:0] idx,
    output logic         last
);

    localparam int unsigned Depth = 2 ** N;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx <= '0;
        end else if (advance) begin
            idx <= idx + N'(1);
        end
    end

    assign last = (idx == N'(Depth - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all 2**N input vectors through an external combinational function,
// captures its truth table and compares it with an expected mask.
// Optional macro TTS_SETTLE_EN: each vector takes two cycles (DRIVE, SAMPLE).
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   start       : sweep request, honoured only in IDLE
//   exp_mask    : expected truth table, latched on accepted start
//   f_in        : output of the function under control
//   vec         : vector presented to the function (0 outside a sweep)
//   busy        : sweep in progress
//   done        : one-cycle completion pulse
//   result      : captured truth table
//   ones_cnt    : number of ones in result
//   match       : result equals latched mask (valid from done)
//   fail_vld    : at least one mismatch (valid from done)
//   first_fail  : lowest mismatching index, 0 if none
module truth_table_sequencer
    import tts_pkg::*;
#(
    parameter int unsigned N = TTS_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2**N-1:0]   exp_mask,
    input  logic              f_in,
    output logic [N-1:0]      vec,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   result,
    output logic [N:0]        ones_cnt,
    output logic              match,
    output logic              fail_vld,
    output logic [N-1:0]      first_fail
);

    tts_state_t        state;
    tts_state_t        state_next;
    logic [2**N-1:0]   mask;
    logic [N-1:0]      idx;
    logic              last;
    logic              accept;
    logic              sample_now;
    logic              mismatch;

    assign accept = (state == ST_IDLE) && start;

`ifdef TTS_SETTLE_EN
    assign sample_now = (state == ST_SAMPLE);
`else
    assign sample_now = (state == ST_DRIVE);
`endif

    assign mismatch = (f_in != mask[idx]);

    tts_vec_counter #(
        .N (N)
    ) u_vec_counter (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .advance (sample_now),
        .idx     (idx),
        .last    (last)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_DRIVE;
`ifdef TTS_SETTLE_EN
            ST_DRIVE:  state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = last ? ST_FINISH : ST_DRIVE;
`else
            ST_DRIVE:  if (last) state_next = ST_FINISH;
`endif
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            mask       <= '0;
            result     <= '0;
            ones_cnt   <= '0;
            match      <= 1'b0;
            fail_vld   <= 1'b0;
            first_fail <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                mask       <= exp_mask;
                result     <= '0;
                ones_cnt   <= '0;
                match      <= 1'b0;
                fail_vld   <= 1'b0;
                first_fail <= '0;
            end else if (sample_now) begin
                result[idx] <= f_in;
                if (f_in) begin
                    ones_cnt <= ones_cnt + (N + 1)'(1);
                end
                // Only the first mismatch records its index.
                if (mismatch && !fail_vld) begin
                    fail_vld   <= 1'b1;
                    first_fail <= idx;
                end
                // Settle match with the final sample so it is valid alongside done.
                if (last) begin
                    match <= !(fail_vld || mismatch);
                end
            end
        end
    end

    assign busy = (state == ST_DRIVE) || (state == ST_SAMPLE);
    assign done = (state == ST_FINISH);
    assign vec  = busy ? idx : '0;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed self-checking bench for truth_table_sequencer with N=4.
// f_in comes from an SoP over minterms {0,3,4,8,10,11,14} (table 16'h4D19),
// or is tied high when f_one is set.
module tb_truth_table_sequencer;

    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 16;
`ifdef TTS_SETTLE_EN
    localparam int CPV = 2;
`else
    localparam int CPV = 1;
`endif
    localparam int SWEEP = DEPTH * CPV;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DEPTH-1:0]  exp_mask;
    logic              f_in;
    logic              f_one;
    logic [N-1:0]      vec;
    logic              busy;
    logic              done;
    logic [DEPTH-1:0]  result;
    logic [N:0]        ones_cnt;
    logic              match;
    logic              fail_vld;
    logic [N-1:0]      first_fail;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    truth_table_sequencer #(
        .N (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .exp_mask   (exp_mask),
        .f_in       (f_in),
        .vec        (vec),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .ones_cnt   (ones_cnt),
        .match      (match),
        .fail_vld   (fail_vld),
        .first_fail (first_fail)
    );

    // x = v[3], y = v[2], w = v[1], z = v[0]
    function automatic logic sop(input logic [3:0] v);
        logic x, y, w, z;
        x = v[3]; y = v[2]; w = v[1]; z = v[0];
        return (~x & ~y & ~w & ~z) | (~x & ~y &  w &  z) | (~x &  y & ~w & ~z) |
               ( x & ~y & ~w & ~z) | ( x & ~y &  w & ~z) | ( x & ~y &  w &  z) |
               ( x &  y &  w & ~z);
    endfunction

    assign f_in = f_one | sop(vec);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input logic [15:0] res, input int ones,
                               input logic m, input logic fv, input int ff);
        chk({tag, ".result"}, 32'(result), 32'(res));
        chk({tag, ".ones_cnt"}, 32'(ones_cnt), ones);
        chk({tag, ".match"}, 32'(match), 32'(m));
        chk({tag, ".fail_vld"}, 32'(fail_vld), 32'(fv));
        chk({tag, ".first_fail"}, 32'(first_fail), ff);
    endtask

    // Start accepted at edge k; c indexes cycle k+c. Optional second start in restart_at.
    task automatic run_sweep(input string tag, input logic [15:0] mask, input int restart_at);
        exp_mask = mask;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= SWEEP + 3; c++) begin
            chk({tag, ".vec"}, 32'(vec), (c <= SWEEP) ? (c - 1) / CPV : 0);
            chk({tag, ".busy"}, 32'(busy), (c <= SWEEP) ? 1 : 0);
            chk({tag, ".done"}, 32'(done), (c == SWEEP + 1) ? 1 : 0);
            if (c == restart_at) start = 1'b1;
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        f_one    = 1'b0;
        exp_mask = '0;
        tick();
        // reset beats start
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst.vec", 32'(vec), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk_outputs("rst", 16'h0000, 0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        tick();
        chk("idle.busy", 32'(busy), 0);

        // Matching sweep
        run_sweep("pass", 16'h4D19, 0);
        chk_outputs("pass", 16'h4D19, 7, 1'b1, 1'b0, 0);

        // Mismatch at bit 1
        run_sweep("miss", 16'h4D1B, 0);
        chk_outputs("miss", 16'h4D19, 7, 1'b0, 1'b1, 1);
        repeat (3) tick();
        chk_outputs("hold", 16'h4D19, 7, 1'b0, 1'b1, 1);

        // Second start mid-sweep must be ignored
        run_sweep("restart", 16'h4D19, 5);
        chk_outputs("restart", 16'h4D19, 7, 1'b1, 1'b0, 0);

        // Reset in cycle k+8
        exp_mask = 16'h4D19;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("pre_rst.busy", 32'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst.vec", 32'(vec), 0);
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.done", 32'(done), 0);
        chk_outputs("midrst", 16'h0000, 0, 1'b0, 1'b0, 0);
        tick();
        chk("midrst.idle", 32'(busy), 0);
        run_sweep("after_rst", 16'h4D19, 0);
        chk_outputs("after_rst", 16'h4D19, 7, 1'b1, 1'b0, 0);

        // All-ones function: ones_cnt reaches 16
        f_one = 1'b1;
        run_sweep("ones", 16'hFFFF, 0);
        chk_outputs("ones", 16'hFFFF, 16, 1'b1, 1'b0, 0);
        f_one = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 Parameter: N, 4, number of function inputs; table depth 2**N; legal range 2..6.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to sweep the table; sampled only in IDLE.
REQ-005 exp_mask  input  2**N  expected truth table (bit i = expected f for vector i); captured on accepted start.
REQ-006 f_in  input  1  output of the combinational function under control (for example, an N-input SoP).
REQ-007 vec  output  N  vector driven to the function; vec[N-1] is the first operand (x), vec[0] the last (z).
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse when the sweep completes.
REQ-010 result  output  2**N  captured truth table; bit i = f_in sampled for vector i.
REQ-011 ones_cnt  output  N+1  number of 1 bits in result.
REQ-012 match  output  1  result == captured exp_mask; valid from done onward.
REQ-013 fail_vld  output  1  at least one mismatch; valid from done onward.
REQ-014 first_fail  output  N  lowest mismatching vector index; 0 when fail_vld=0.

Function
REQ-015 States: IDLE, DRIVE, SAMPLE (TTS_SETTLE_EN only), FINISH.
- IDLE: start=1 -> DRIVE; idx=0; result, ones_cnt, fail_vld, first_fail and match cleared; exp_mask latched.
REQ-016 vec = idx in DRIVE/SAMPLE; vec = 0 in IDLE/FINISH.
REQ-017 Without settle: each DRIVE cycle samples f_in into result[idx] at the cycle's closing edge; it also updates ones_cnt and the mismatch tracking, then idx+1.
REQ-018 Mismatch tracking: on the first bit with f_in != exp_mask[idx], set fail_vld=1 and first_fail=idx; later mismatches leave first_fail unchanged.
REQ-019 Last vector: after the sample at idx = 2**N-1 -> FINISH; idx does not wrap into another sweep.
REQ-020 FINISH lasts exactly one cycle:
- done=1, match=~fail_vld;
- then -> IDLE.
REQ-021 Latency: start accepted at edge k -> vec=0 from cycle k+1, done high in cycle k+2**N+1 (k+17 for N=4); busy high cycles k+1..k+2**N.
REQ-022 start while busy or in FINISH is ignored; no queuing.
REQ-023 result, ones_cnt, match, fail_vld and first_fail hold their values in IDLE until the next accepted start.
REQ-024 ones_cnt saturates only by construction; its maximum is 2**N, which fits in N+1 bits.

Reset
REQ-025 reset=1 at any edge, including mid-sweep: state=IDLE, idx=0, vec=0, busy=0, done=0, result=0, ones_cnt=0, match=0, fail_vld=0, first_fail=0, latched mask=0.
REQ-026 reset has priority over start in the same cycle.

Configuration
REQ-027 Macro TTS_SETTLE_EN:
- Defined: each vector takes two cycles. DRIVE presents vec, then SAMPLE captures f_in and advances idx. done falls in cycle k+2*2**N+1 (k+33 for N=4); vec is stable through both cycles.
- Undefined: the SAMPLE state is absent and behaviour follows REQ-017/REQ-021.

Structure
REQ-028 Shared package tts_pkg holds:
- the state enum;
- default N;
- localparam DEPTH=2**N.
REQ-029 Sub-module tts_vec_counter holds idx generation: clear, advance and last-vector flag.
REQ-030 The function under control is external; the block has no function logic of its own.

Verification
REQ-031 Bench with N=4 drives f_in from an SoP of minterms {0,3,4,8,10,11,14}, with exp_mask=16'h4D19. Required response: done at k+17, result=16'h4D19, ones_cnt=7, match=1, fail_vld=0.
REQ-032 Same SoP with exp_mask=16'h4D1B -> fail_vld=1, first_fail=1, match=0, result=16'h4D19.
REQ-033 start pulsed again in cycle k+5 -> ignored; done occurs once, at k+17.
REQ-034 reset asserted in cycle k+8 -> all outputs 0 next cycle; a subsequent start runs a full sweep to the correct result.
REQ-035 f_in tied to 1, exp_mask=16'hFFFF -> ones_cnt=16 (5'b10000), match=1.
REQ-036 With TTS_SETTLE_EN defined, repeat REQ-031 -> done at k+33; each vec value is held for two consecutive cycles; result=16'h4D19.
